idex_stage: RTL and testbench



---
 rtl/idex_if.sv | 38 +++
 rtl/idex_stage.sv | 145 ++++++++++++++
 tb/tb_idex_stage.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/idex_if.sv
// Decode-to-execute bundle: instruction/PC inputs and the registered execute-stage controls.
// FLUSH exists only when IDEX_FLUSH_EN is defined.
interface idex_if;
    logic [31:0] InPC;
    logic [31:0] Inst;
`ifdef IDEX_FLUSH_EN
    logic        FLUSH;
`endif
    logic [31:0] PC;
    logic [3:0]  ALUControl;
    logic [1:0]  ALUSourceA;
    logic [2:0]  ALUSourceB;
    logic        DmemREB;
    logic        DmemWEB;
    logic        Dmem1ALUOUT;
    logic        RegWrite;
    logic [31:0] LoadStore32Address;
    logic [31:0] LoadStoreOrjalAddress;
    logic [31:0] auipcOrlui;

    modport master (
`ifdef IDEX_FLUSH_EN
        output FLUSH,
`endif
        output InPC, Inst,
        input  PC, ALUControl, ALUSourceA, ALUSourceB, DmemREB, DmemWEB, Dmem1ALUOUT,
        input  RegWrite, LoadStore32Address, LoadStoreOrjalAddress, auipcOrlui
    );

    modport slave (
`ifdef IDEX_FLUSH_EN
        input  FLUSH,
`endif
        input  InPC, Inst,
        output PC, ALUControl, ALUSourceA, ALUSourceB, DmemREB, DmemWEB, Dmem1ALUOUT,
        output RegWrite, LoadStore32Address, LoadStoreOrjalAddress, auipcOrlui
    );
endinterface

// File: rtl/idex_stage.sv
// RV32I decode stage plus ID/EX register: decodes controls and immediates, registers them once.
// Optional IDEX_FLUSH_EN adds a FLUSH input that loads a bubble with zeroed PC/immediates.
module idex_stage (
    input  logic CLK,
    input  logic RST,
    idex_if.slave bus_io
);
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  alu;
        logic [1:0]  src_a;
        logic [2:0]  src_b;
        logic        reb;
        logic        web;
        logic        mem_to_reg;
        logic        reg_write;
        logic [31:0] ls_addr;
        logic [31:0] lsj_addr;
        logic [31:0] upper;
    } idex_t;

    localparam idex_t Bubble = '{reb: 1'b1, web: 1'b1, default: '0};

    idex_t dec;
    idex_t idex_d, idex_q;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b;
    logic [11:0] ls12;
    logic [3:0]  alu_f3;

    assign inst    = bus_io.Inst;
    assign opcode  = inst[6:0];
    assign funct3  = inst[14:12];
    assign funct7b = inst[30];

    // funct3 decode shared by OP and OP-IMM; SUB is added only for OP below
    always_comb begin
        alu_f3 = 4'b0000;
        unique case (funct3)
            3'b000: alu_f3 = 4'b0000;
            3'b001: alu_f3 = 4'b0010;
            3'b010: alu_f3 = 4'b0011;
            3'b011: alu_f3 = 4'b0100;
            3'b100: alu_f3 = 4'b0101;
            3'b101: alu_f3 = funct7b ? 4'b0111 : 4'b0110;
            3'b110: alu_f3 = 4'b1000;
            3'b111: alu_f3 = 4'b1001;
            default: alu_f3 = 4'b0000;
        endcase
    end

    always_comb begin
        dec       = Bubble;
        dec.pc    = bus_io.InPC;
        dec.upper = {inst[31:12], 12'b0};
        ls12      = (opcode == OpStore) ? {inst[31:25], inst[11:7]} : inst[31:20];
        dec.ls_addr = {{20{ls12[11]}}, ls12};
        case (opcode)
            OpJal:    dec.lsj_addr = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                                      inst[30:21], 1'b0};
            OpBranch: dec.lsj_addr = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                                      inst[11:8], 1'b0};
            default:  dec.lsj_addr = dec.ls_addr;
        endcase

        case (opcode)
            OpOp: begin
                dec.alu       = (funct3 == 3'b000 && funct7b) ? 4'b0001 : alu_f3;
                dec.reg_write = 1'b1;
            end
            OpOpImm: begin
                dec.alu       = alu_f3;
                dec.src_b     = 3'b001;
                dec.reg_write = 1'b1;
            end
            OpLoad: begin
                dec.src_b      = 3'b001;
                dec.reb        = 1'b0;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
            end
            OpStore: begin
                dec.src_b = 3'b010;
                dec.web   = 1'b0;
            end
            OpLui: begin
                dec.src_a     = 2'b10;
                dec.src_b     = 3'b011;
                dec.reg_write = 1'b1;
            end
            OpAuipc: begin
                dec.src_a     = 2'b01;
                dec.src_b     = 3'b011;
                dec.reg_write = 1'b1;
            end
            OpJal, OpJalr: begin
                dec.src_a     = 2'b01;
                dec.src_b     = 3'b100;
                dec.reg_write = 1'b1;
            end
            OpBranch: dec.alu = 4'b0001;
            default: ;
        endcase
    end

`ifdef IDEX_FLUSH_EN
    assign idex_d = bus_io.FLUSH ? Bubble : dec;
`else
    assign idex_d = dec;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            idex_q <= Bubble;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign bus_io.PC                    = idex_q.pc;
    assign bus_io.ALUControl            = idex_q.alu;
    assign bus_io.ALUSourceA            = idex_q.src_a;
    assign bus_io.ALUSourceB            = idex_q.src_b;
    assign bus_io.DmemREB               = idex_q.reb;
    assign bus_io.DmemWEB               = idex_q.web;
    assign bus_io.Dmem1ALUOUT           = idex_q.mem_to_reg;
    assign bus_io.RegWrite              = idex_q.reg_write;
    assign bus_io.LoadStore32Address    = idex_q.ls_addr;
    assign bus_io.LoadStoreOrjalAddress = idex_q.lsj_addr;
    assign bus_io.auipcOrlui            = idex_q.upper;

endmodule

// File: tb/tb_idex_stage.sv
// Scoreboard bench for idex_stage: driver pushes reference-model expectations, monitor pops
// and compares one cycle later. Honours IDEX_FLUSH_EN.
module tb_idex_stage;
    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  alu;
        logic [1:0]  a;
        logic [2:0]  b;
        logic        reb;
        logic        web;
        logic        dm;
        logic        rw;
        logic [31:0] ls;
        logic [31:0] lsj;
        logic [31:0] ui;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    idex_if bus ();

    idex_stage dut (
        .CLK    (clk),
        .RST    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    // Reference model written from the instruction-format rules with plain arithmetic.
    function automatic exp_t model(input logic r, input logic fl, input logic [31:0] pc,
                                   input logic [31:0] inst);
        exp_t e;
        int   s;
        int   alu_tbl [8];
        logic signed [20:0] jimm;
        logic signed [12:0] bimm;
        logic [6:0] op;
        logic [2:0] f3;
        e = '0;
        e.reb = 1'b1;
        e.web = 1'b1;
        if (r || fl) return e;
        alu_tbl = '{0, 2, 3, 4, 5, 6, 8, 9};
        op = inst[6:0];
        f3 = inst[14:12];
        s = int'(inst);
        e.pc = pc;
        e.ui = {inst[31:12], 12'h000};
        if (op == 7'h23) e.ls = 32'((s >>> 25) * 32 + int'({27'd0, inst[11:7]}));
        else             e.ls = 32'(s >>> 20);
        jimm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        bimm = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        if (op == 7'h6F)      e.lsj = 32'(int'(jimm));
        else if (op == 7'h63) e.lsj = 32'(int'(bimm));
        else                  e.lsj = e.ls;
        case (op)
            7'h33, 7'h13: begin
                e.alu = 4'(alu_tbl[f3]);
                if (inst[30] && (f3 == 3'd5 || (f3 == 3'd0 && op == 7'h33))) e.alu = e.alu + 4'd1;
                e.b  = (op == 7'h13) ? 3'd1 : 3'd0;
                e.rw = 1'b1;
            end
            7'h03: begin e.b = 3'd1; e.reb = 1'b0; e.dm = 1'b1; e.rw = 1'b1; end
            7'h23: begin e.b = 3'd2; e.web = 1'b0; end
            7'h37: begin e.a = 2'd2; e.b = 3'd3; e.rw = 1'b1; end
            7'h17: begin e.a = 2'd1; e.b = 3'd3; e.rw = 1'b1; end
            7'h6F, 7'h67: begin e.a = 2'd1; e.b = 3'd4; e.rw = 1'b1; end
            7'h63: e.alu = 4'd1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic apply(input logic r, input logic fl, input logic [31:0] pc,
                         input logic [31:0] inst);
        logic fl_eff;
        @(negedge clk);
        rst = r;
        bus.InPC = pc;
        bus.Inst = inst;
`ifdef IDEX_FLUSH_EN
        bus.FLUSH = fl;
        fl_eff = fl;
`else
        fl_eff = 1'b0;
`endif
        sb.push_back(model(r, fl_eff, pc, inst));
    endtask

    // Monitor: every cycle the stage presents a registered result, one behind the driver.
    initial begin
        exp_t exp_v;
        exp_t act;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_v = sb.pop_front();
                act = {bus.PC, bus.ALUControl, bus.ALUSourceA, bus.ALUSourceB, bus.DmemREB,
                       bus.DmemWEB, bus.Dmem1ALUOUT, bus.RegWrite, bus.LoadStore32Address,
                       bus.LoadStoreOrjalAddress, bus.auipcOrlui};
                checks++;
                if (act !== exp_v) begin
                    failures++;
                    $display("FAIL decode t=%0t act pc=%h alu=%h a=%h b=%h reb=%b web=%b dm=%b rw=%b ls=%h lsj=%h ui=%h | req pc=%h alu=%h a=%h b=%h reb=%b web=%b dm=%b rw=%b ls=%h lsj=%h ui=%h",
                             $time, act.pc, act.alu, act.a, act.b, act.reb, act.web, act.dm,
                             act.rw, act.ls, act.lsj, act.ui, exp_v.pc, exp_v.alu, exp_v.a,
                             exp_v.b, exp_v.reb, exp_v.web, exp_v.dm, exp_v.rw, exp_v.ls,
                             exp_v.lsj, exp_v.ui);
                end
            end
        end
    end

    initial begin
        logic [6:0]  ops [10];
        logic [31:0] inst;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h00};
        bus.InPC = '0;
        bus.Inst = '0;
`ifdef IDEX_FLUSH_EN
        bus.FLUSH = 1'b0;
`endif
        apply(1'b1, 1'b0, 32'h0, 32'h00500093);
        apply(1'b1, 1'b0, 32'h0, 32'h00500093);
        apply(1'b0, 1'b0, 32'h0, 32'h00500093);
        apply(1'b0, 1'b0, 32'h4, 32'hFFC0A103);
        apply(1'b0, 1'b0, 32'h8, 32'h0020A423);
        apply(1'b0, 1'b0, 32'hC, 32'h123452B7);
        apply(1'b0, 1'b0, 32'h40, 32'h008000EF);
        apply(1'b0, 1'b0, 32'h44, 32'h40208033);
        apply(1'b0, 1'b0, 32'h48, 32'h0000007F);
        apply(1'b0, 1'b1, 32'h4C, 32'h00500093);
        apply(1'b1, 1'b1, 32'h50, 32'h40208033);
        apply(1'b0, 1'b0, 32'h54, 32'h00000000);
        for (int i = 0; i < 400; i++) begin
            inst = $urandom;
            if ($urandom_range(0, 9) != 9) inst[6:0] = ops[$urandom_range(0, 9)];
            apply($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, $urandom, inst);
        end
        apply(1'b0, 1'b0, 32'h100, 32'h00000013);
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain act=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
